// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and types for the X9 register file slice.
//   DW_DEFAULT / PW_DEFAULT : default data / address widths
//   word_t / raddr_t        : default-width data word and register address
//   nregs()                 : register count for a given address width
package reg_file_pkg;
  localparam int DW_DEFAULT = 8;
  localparam int PW_DEFAULT = 3;

  typedef logic [DW_DEFAULT-1:0] word_t;
  typedef logic [PW_DEFAULT-1:0] raddr_t;

  function automatic int nregs(input int pw);
    return 1 << pw;
  endfunction
endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: per-register busy bits for registers awaiting a
// long-latency result.
//   clk, reset         : clock, async active-high clear of all busy bits
//   rsv_en/rsv_addr    : reservation (sets busy)
//   wr_en/wr_addr      : writeback (clears busy; reservation wins on a tie)
//   rd_addrA/rd_addrB  : read addresses whose busy state is reported
//   busyA/busyB        : busy state seen by each read port
//   any_busy           : OR of all busy bits
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int PW       = PW_DEFAULT,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rsv_en,
  input  logic [PW-1:0] rsv_addr,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [PW-1:0] rd_addrA,
  input  logic [PW-1:0] rd_addrB,
  output logic          busyA,
  output logic          busyB,
  output logic          any_busy
);
  localparam int NR = 1 << PW;

  logic [NR-1:0] r_busy;
  logic [NR-1:0] w_busy_nxt;
  logic          w_rsv_ok;
  logic          w_wr_ok;
  logic          w_fwdA;
  logic          w_fwdB;

  // Register 0 never tracks anything when it is hardwired to zero.
  assign w_rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
  assign w_wr_ok  = wr_en  && !(ZERO_REG != 0 && wr_addr  == '0);

  // New producer supersedes the retiring one, so set has priority.
  for (genvar i = 0; i < NR; i++) begin : g_nxt
    assign w_busy_nxt[i] = (w_rsv_ok && rsv_addr == PW'(i)) ? 1'b1 :
                           (w_wr_ok  && wr_addr  == PW'(i)) ? 1'b0 :
                           r_busy[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  // A same-cycle write retires the producer early for the reader, unless a
  // new reservation for that register lands on the same edge.
  assign w_fwdA = (BYPASS != 0) && w_wr_ok && wr_addr == rd_addrA &&
                  !(w_rsv_ok && rsv_addr == rd_addrA);
  assign w_fwdB = (BYPASS != 0) && w_wr_ok && wr_addr == rd_addrB &&
                  !(w_rsv_ok && rsv_addr == rd_addrB);

  assign busyA    = w_fwdA ? 1'b0 : r_busy[rd_addrA];
  assign busyB    = w_fwdB ? 1'b0 : r_busy[rd_addrB];
  assign any_busy = |r_busy;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2**PW x DW register file, two combinational read ports, one
// synchronous write port, optional write-to-read bypass and hardwired r0,
// plus a busy scoreboard for multi-cycle producers.
//   clk, reset          : clock, async active-high clear of data and busy
//   rd_addrA/rd_addrB   : read addresses
//   wr_en/wr_addr/dat_in: write port
//   rsv_en/rsv_addr     : reservation port
//   datA_out/datB_out   : read data
//   busyA/busyB/any_busy: scoreboard status
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int PW       = PW_DEFAULT,
  parameter int DW       = DW_DEFAULT,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] rd_addrA,
  input  logic [PW-1:0] rd_addrB,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [DW-1:0] dat_in,
  input  logic          rsv_en,
  input  logic [PW-1:0] rsv_addr,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  output logic          busyA,
  output logic          busyB,
  output logic          any_busy
);
  localparam int NR = 1 << PW;

  logic [NR-1:0][DW-1:0] r_core;
  logic [1:0][PW-1:0]    w_rd_addr;
  logic [1:0][DW-1:0]    w_rd_dat;
  logic                  w_wr_ok;

  assign w_wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_core <= '0;
    else if (w_wr_ok) r_core[wr_addr] <= dat_in;
  end

  assign w_rd_addr = {rd_addrB, rd_addrA};

  // Bypass is suppressed during reset so outputs read 0 while it is held.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    assign w_rd_dat[p] =
      (ZERO_REG != 0 && w_rd_addr[p] == '0)                     ? '0     :
      (BYPASS != 0 && !reset && w_wr_ok && wr_addr == w_rd_addr[p]) ? dat_in :
      r_core[w_rd_addr[p]];
  end

  assign datA_out = w_rd_dat[0];
  assign datB_out = w_rd_dat[1];

  reg_file_scoreboard #(
    .PW       (PW),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_addrA (rd_addrA),
    .rd_addrB (rd_addrB),
    .busyA    (busyA),
    .busyB    (busyB),
    .any_busy (any_busy)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: three configurations (BYPASS=0; BYPASS=1; BYPASS=1 with
// ZERO_REG=1) share one stimulus stream and are checked against an
// array-based reference model of the register file and busy table.
module tb_reg_file_sb;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rd_addrA, rd_addrB, wr_addr, rsv_addr;
  logic       wr_en, rsv_en;
  logic [7:0] dat_in;

  logic [7:0] datA [3];
  logic [7:0] datB [3];
  logic       busyA [3];
  logic       busyB [3];
  logic       anyb [3];

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [7:0] m [3][8];
  bit         b [3][8];

  always #5 clk = ~clk;

  reg_file_sb #(.PW(3), .DW(8), .BYPASS(0), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .reset(reset), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .datA_out(datA[0]), .datB_out(datB[0]),
    .busyA(busyA[0]), .busyB(busyB[0]), .any_busy(anyb[0]));

  reg_file_sb #(.PW(3), .DW(8), .BYPASS(1), .ZERO_REG(0)) u_dut1 (
    .clk(clk), .reset(reset), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .datA_out(datA[1]), .datB_out(datB[1]),
    .busyA(busyA[1]), .busyB(busyB[1]), .any_busy(anyb[1]));

  reg_file_sb #(.PW(3), .DW(8), .BYPASS(1), .ZERO_REG(1)) u_dut2 (
    .clk(clk), .reset(reset), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .datA_out(datA[2]), .datB_out(datB[2]),
    .busyA(busyA[2]), .busyB(busyB[2]), .any_busy(anyb[2]));

  function automatic bit cfg_bp(input int c);
    return c != 0;
  endfunction

  function automatic bit cfg_zr(input int c);
    return c == 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] e_dat(input int c, input logic [2:0] ra);
    if (reset) return 8'h00;
    if (cfg_zr(c) && ra == 3'd0) return 8'h00;
    if (cfg_bp(c) && wr_en && wr_addr == ra) return dat_in;
    return m[c][ra];
  endfunction

  function automatic logic e_busy(input int c, input logic [2:0] ra);
    if (reset) return 1'b0;
    if (cfg_zr(c) && ra == 3'd0) return 1'b0;
    if (cfg_bp(c) && wr_en && wr_addr == ra && !(rsv_en && rsv_addr == ra)) return 1'b0;
    return b[c][ra];
  endfunction

  function automatic logic e_any(input int c);
    logic r = 1'b0;
    if (reset) return 1'b0;
    for (int i = 0; i < 8; i++) r |= b[c][i];
    return r;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 8; i++) begin
        m[c][i] = 8'h00;
        b[c][i] = 1'b0;
      end
  endtask

  task automatic model_edge();
    if (reset) return;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 8; i++) begin
        if (cfg_zr(c) && i == 0) continue;
        if (rsv_en && rsv_addr == 3'(i))     b[c][i] = 1'b1;
        else if (wr_en && wr_addr == 3'(i))  b[c][i] = 1'b0;
      end
      if (wr_en && !(cfg_zr(c) && wr_addr == 3'd0)) m[c][wr_addr] = dat_in;
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("datA%0d", c),  32'(datA[c]),  32'(e_dat(c, rd_addrA)));
      chk($sformatf("datB%0d", c),  32'(datB[c]),  32'(e_dat(c, rd_addrB)));
      chk($sformatf("busyA%0d", c), 32'(busyA[c]), 32'(e_busy(c, rd_addrA)));
      chk($sformatf("busyB%0d", c), 32'(busyB[c]), 32'(e_busy(c, rd_addrB)));
      chk($sformatf("any%0d", c),   32'(anyb[c]),  32'(e_any(c)));
    end
  endtask

  // Called just after a negedge with inputs applied: check, take the edge.
  task automatic cyc();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; dat_in = d; rsv_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear_model();
    rd_addrA = '0; rd_addrB = '0; wr_addr = '0; rsv_addr = '0;
    wr_en = 1'b0; rsv_en = 1'b0; dat_in = '0;
    #1 check_all();
    @(negedge clk); reset = 1'b0;

    // 1: write r3, pre-edge view differs by bypass, then visible everywhere
    wr(3'd3, 8'hA5); rd_addrA = 3'd3;
    #1 chk("t1_pre_nobp", 32'(datA[0]), 32'h00);
    chk("t1_pre_bp", 32'(datA[1]), 32'hA5);
    cyc();
    idle();
    #1 chk("t1_post", 32'(datA[0]), 32'hA5);
    chk("t1_busy", 32'(busyA[0]), 32'h0);
    cyc();

    // 2: bypass of r5
    wr(3'd5, 8'h3C); rd_addrA = 3'd5;
    #1 chk("t2_bp", 32'(datA[1]), 32'h3C);
    cyc();

    // 3: reserve r2, then retire it
    idle(); rsv_en = 1'b1; rsv_addr = 3'd2; rd_addrB = 3'd2;
    cyc();
    idle();
    #1 chk("t3_busy", 32'(busyB[0]), 32'h1);
    chk("t3_any", 32'(anyb[0]), 32'h1);
    cyc();
    wr(3'd2, 8'h11);
    cyc();
    idle();
    #1 chk("t3_clr", 32'(busyB[0]), 32'h0);
    chk("t3_dat", 32'(datB[0]), 32'h11);
    chk("t3_any0", 32'(anyb[0]), 32'h0);
    cyc();

    // 4: reserve and write r4 on the same edge
    wr(3'd4, 8'h77); rsv_en = 1'b1; rsv_addr = 3'd4; rd_addrA = 3'd4;
    cyc();
    idle();
    #1 chk("t4_dat", 32'(datA[0]), 32'h77);
    chk("t4_busy", 32'(busyA[0]), 32'h1);
    cyc();
    wr(3'd4, 8'h78);
    cyc();

    // 5: r0 writes/reservations ignored when hardwired
    wr(3'd0, 8'hFF); rsv_en = 1'b1; rsv_addr = 3'd0; rd_addrA = 3'd0;
    cyc();
    idle();
    #1 chk("t5_dat", 32'(datA[2]), 32'h00);
    chk("t5_busy", 32'(busyA[2]), 32'h0);
    chk("t5_any", 32'(anyb[2]), 32'h0);
    chk("t5_r0_plain", 32'(datA[0]), 32'hFF);
    cyc();

    // 6: fill, reserve, async reset between edges, then one write
    for (int i = 0; i < 8; i++) begin
      wr(3'(i), 8'(i + 1)); rd_addrA = 3'(i); rd_addrB = 3'(7 - i);
      cyc();
    end
    idle(); rsv_en = 1'b1; rsv_addr = 3'd6;
    cyc();
    wr(3'd6, 8'hEE); rd_addrA = 3'd6; rd_addrB = 3'd1;
    #2 reset = 1'b1; clear_model();
    #1 chk("t6_any", 32'(anyb[0]), 32'h0);
    chk("t6_bp_rst", 32'(datA[1]), 32'h00);
    check_all();
    @(posedge clk); model_edge();
    @(negedge clk); reset = 1'b0;
    wr(3'd1, 8'h09);
    cyc();
    idle();
    for (int i = 0; i < 8; i++) begin
      rd_addrA = 3'(i);
      #1 chk($sformatf("t6_r%0d", i), 32'(datA[0]), (i == 1) ? 32'h09 : 32'h00);
      cyc();
    end

    // random traffic with occasional mid-cycle resets
    for (int n = 0; n < 600; n++) begin
      rd_addrA = 3'($urandom_range(0, 7));
      rd_addrB = ($urandom_range(0, 3) == 0) ? rd_addrA : 3'($urandom_range(0, 7));
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = ($urandom_range(0, 2) == 0) ? rd_addrA : 3'($urandom_range(0, 7));
      dat_in   = 8'($urandom);
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = ($urandom_range(0, 2) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1; clear_model();
      end else begin
        reset = 1'b0;
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
